// File: rtl/uart_peripheral.sv
// Memory-mapped 8N1 UART responder: one transmitter and one receiver, fully
// independent, sharing a fixed baud set by CLKS_PER_BIT.
module uart_peripheral #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_send,
  input  logic [31:0] tx_wrdata,
  input  logic        rx_clear,
  input  logic        rx,
  output logic        tx,
  output logic        uart_busy,
  output logic        uart_rx_flag,
  output logic [31:0] uart_rddata
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_HALF = CNT_W'(CLKS_PER_BIT / 2);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t           tx_state, rx_state;
  logic [CNT_W-1:0] tx_cnt, rx_cnt;
  logic [2:0]       tx_idx, rx_idx;
  logic [7:0]       tx_shift, rx_shift, rx_byte;
  logic             rx_s1, rx_s2, rx_ferr;

  // Only the low byte of the write data is a character; the rest is don't-care.
  logic unused_wrdata;
  assign unused_wrdata = ^tx_wrdata[31:8];

  assign uart_rddata = {24'h0, rx_byte};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state  <= S_IDLE;
      tx_cnt    <= '0;
      tx_idx    <= '0;
      tx_shift  <= '0;
      tx        <= 1'b1;
      uart_busy <= 1'b0;
    end else begin
      case (tx_state)
        S_IDLE: begin
          if (tx_send) begin
            tx_shift  <= tx_wrdata[7:0];
            tx_cnt    <= '0;
            tx_idx    <= '0;
            tx        <= 1'b0;
            uart_busy <= 1'b1;
            tx_state  <= S_START;
          end
        end
        S_START: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt   <= '0;
            tx       <= tx_shift[0];
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_state <= S_DATA;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt <= '0;
            if (tx_idx == 3'd7) begin
              tx       <= 1'b1;
              tx_state <= S_STOP;
            end else begin
              tx_idx   <= tx_idx + 3'd1;
              tx       <= tx_shift[0];
              tx_shift <= {1'b0, tx_shift[7:1]};
            end
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (tx_cnt == BIT_LAST) begin
            tx_cnt    <= '0;
            uart_busy <= 1'b0;
            tx_state  <= S_IDLE;
          end else begin
            tx_cnt <= tx_cnt + 1'b1;
          end
        end
        default: tx_state <= S_IDLE;
      endcase
    end
  end

  // Synchronizer idles high so reset never looks like a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state     <= S_IDLE;
      rx_cnt       <= '0;
      rx_idx       <= '0;
      rx_shift     <= '0;
      rx_byte      <= '0;
      rx_ferr      <= 1'b0;
      uart_rx_flag <= 1'b0;
    end else begin
      // A byte completing in the same cycle overrides this clear below.
      if (rx_clear) uart_rx_flag <= 1'b0;
      case (rx_state)
        S_IDLE: begin
          if (!rx_s2) begin
            rx_cnt   <= '0;
            rx_state <= S_START;
          end
        end
        S_START: begin
          if (rx_cnt == BIT_HALF) begin
            rx_cnt   <= '0;
            rx_idx   <= '0;
            rx_state <= rx_s2 ? S_IDLE : S_DATA;
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            if (rx_idx == 3'd7) begin
              rx_ferr  <= 1'b0;
              rx_state <= S_STOP;
            end else begin
              rx_idx <= rx_idx + 3'd1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        S_STOP: begin
          if (rx_ferr) begin
            if (rx_s2) begin
              rx_ferr  <= 1'b0;
              rx_state <= S_IDLE;
            end
          end else if (rx_cnt == BIT_LAST) begin
            rx_cnt <= '0;
            if (rx_s2) begin
              rx_byte      <= rx_shift;
              uart_rx_flag <= 1'b1;
              rx_state     <= S_IDLE;
            end else begin
              rx_ferr <= 1'b1;
            end
          end else begin
            rx_cnt <= rx_cnt + 1'b1;
          end
        end
        default: rx_state <= S_IDLE;
      endcase
    end
  end

endmodule
